// File: rtl/tlul_pkg.sv
// Shared TL-UL constants and the slave FSM state type for the SRAM endpoint.
// Optional wait-state support is controlled by TLUL_SRAM_WAITSTATE_EN (see tlul_sram_slave.sv).
package tlul_pkg;

    // A-channel opcodes
    localparam logic [2:0] A_PUT_FULL    = 3'd0;
    localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] A_GET         = 3'd4;

    // D-channel opcodes
    localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;

    typedef logic [1:0] slv_state_t;

    localparam slv_state_t ST_IDLE = 2'd0;
    localparam slv_state_t ST_WAIT = 2'd1;
    localparam slv_state_t ST_RESP = 2'd2;

endpackage

// File: rtl/tlul_sram_slave_if.sv
// TL-UL A/D channel bundle between a requester (master) and the SRAM endpoint (slave).
// Handshake: a beat transfers on a rising edge where valid & ready; valid-side fields stay stable while valid is high.
interface tlul_sram_slave_if #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int OPCODE_WIDTH = 3,
    parameter int PARAM_WIDTH  = 3,
    parameter int SIZE_WIDTH   = 3,
    parameter int SRC_WIDTH    = 2,
    parameter int SINK_WIDTH   = 1
);
    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    logic                    a_valid;
    logic                    a_ready;
    logic [OPCODE_WIDTH-1:0] a_opcode;
    logic [PARAM_WIDTH-1:0]  a_param;
    logic [SIZE_WIDTH-1:0]   a_size;
    logic [SRC_WIDTH-1:0]    a_source;
    logic [ADDR_WIDTH-1:0]   a_address;
    logic [MASK_WIDTH-1:0]   a_mask;
    logic [DATA_WIDTH-1:0]   a_data;

    logic                    d_valid;
    logic                    d_ready;
    logic [OPCODE_WIDTH-1:0] d_opcode;
    logic [PARAM_WIDTH-1:0]  d_param;
    logic [SIZE_WIDTH-1:0]   d_size;
    logic [SRC_WIDTH-1:0]    d_source;
    logic [SINK_WIDTH-1:0]   d_sink;
    logic [DATA_WIDTH-1:0]   d_data;
    logic                    d_error;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
        input  a_ready,
        input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error,
        output d_ready
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
        output a_ready,
        output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error,
        input  d_ready
    );

endinterface

// File: rtl/tlul_sram_mem.sv
// Word-organised SRAM with per-byte write enables, synchronous write and a registered read port.
// The array and read register are deliberately not reset.
module tlul_sram_mem #(
    parameter int DEPTH      = 8192,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic                    clk_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [IDX_W-1:0]        addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic                    re_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);
    localparam int MW = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < MW; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
        // Read and write never coincide; the read sees the pre-request contents.
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/tlul_sram_slave.sv
// TL-UL SRAM device endpoint: one outstanding request, one D response per accepted A request.
// Define TLUL_SRAM_WAITSTATE_EN to insert WAIT_CYCLES extra cycles of response latency.
module tlul_sram_slave
    import tlul_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    OPCODE_WIDTH = 3,
    parameter int                    PARAM_WIDTH  = 3,
    parameter int                    SIZE_WIDTH   = 3,
    parameter int                    SRC_WIDTH    = 2,
    parameter int                    SINK_WIDTH   = 1,
    parameter int                    DEPTH        = 8192,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter int                    WAIT_CYCLES  = 2
) (
    input  logic               clk_24,
    input  logic               reset_n,
    tlul_sram_slave_if.slave   bus,
    output slv_state_t         dbg_state_o
);
    localparam int MASK_WIDTH = DATA_WIDTH / 8;
    localparam int OFF_W      = $clog2(MASK_WIDTH);
    localparam int IDX_W      = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(DEPTH * MASK_WIDTH);

    slv_state_t state_q, state_d;

    logic                    accept;
    logic                    op_write, op_read, op_bad;
    logic                    size_bad, misaligned, below_base, above_top;
    logic                    req_err;
    logic [ADDR_WIDTH-1:0]   offset;
    logic [ADDR_WIDTH-1:0]   align_mask;
    logic [IDX_W-1:0]        word_idx;
    logic                    mem_we, mem_re;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    logic [OPCODE_WIDTH-1:0] d_opcode_q;
    logic [SIZE_WIDTH-1:0]   d_size_q;
    logic [SRC_WIDTH-1:0]    d_source_q;
    logic                    d_error_q;
    logic                    d_rd_q;

    logic                    wait_go;
    logic                    wait_done;

    // a_ready comes straight from the state register, so a_valid never reaches it combinationally.
    assign bus.a_ready = (state_q == ST_IDLE);
    assign accept      = bus.a_valid & bus.a_ready;

    assign op_write = (bus.a_opcode == OPCODE_WIDTH'(A_PUT_FULL)) ||
                      (bus.a_opcode == OPCODE_WIDTH'(A_PUT_PARTIAL));
    assign op_read  = (bus.a_opcode == OPCODE_WIDTH'(A_GET));
    assign op_bad   = ~(op_write | op_read);
    assign size_bad = (bus.a_size > SIZE_WIDTH'(OFF_W));

    always_comb begin
        align_mask = '0;
        for (int i = 0; i < OFF_W; i++) begin
            if (SIZE_WIDTH'(i) < bus.a_size) begin
                align_mask[i] = 1'b1;
            end
        end
    end

    assign misaligned = |(bus.a_address & align_mask);
    assign offset     = bus.a_address - BASE_ADDR;
    assign below_base = (bus.a_address < BASE_ADDR);
    assign above_top  = ({1'b0, offset} >= SPAN);
    assign req_err    = op_bad | size_bad | misaligned | below_base | above_top;
    assign word_idx   = offset[OFF_W +: IDX_W];

    // Rejected requests never touch the array.
    assign mem_we = accept & op_write & ~req_err;
    assign mem_re = accept & op_read  & ~req_err;

    tlul_sram_mem #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_mem (
        .clk_i   (clk_24),
        .we_i    (mem_we),
        .be_i    (bus.a_mask),
        .addr_i  (word_idx),
        .wdata_i (bus.a_data),
        .re_i    (mem_re),
        .rdata_o (mem_rdata)
    );

`ifdef TLUL_SRAM_WAITSTATE_EN
    localparam bit HAS_WAIT = (WAIT_CYCLES > 0);
    localparam int CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter loads WAIT_CYCLES-1 so WAIT lasts exactly WAIT_CYCLES cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = HAS_WAIT ? CNT_W'(WAIT_CYCLES - 1) : '0;
        end else if ((state_q == ST_WAIT) && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_24 or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign wait_go   = HAS_WAIT;
    assign wait_done = (cnt_q == '0);
`else
    logic unused_wait_cfg;

    assign wait_go         = 1'b0;
    assign wait_done       = 1'b1;
    assign unused_wait_cfg = ^WAIT_CYCLES;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)      state_d = wait_go ? ST_WAIT : ST_RESP;
            ST_WAIT: if (wait_done)   state_d = ST_RESP;
            ST_RESP: if (bus.d_ready) state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_24 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // D fields are captured at accept and held untouched until the next accept.
    always_ff @(posedge clk_24 or negedge reset_n) begin
        if (!reset_n) begin
            d_opcode_q <= '0;
            d_size_q   <= '0;
            d_source_q <= '0;
            d_error_q  <= 1'b0;
            d_rd_q     <= 1'b0;
        end else if (accept) begin
            d_opcode_q <= op_read ? OPCODE_WIDTH'(D_ACCESS_ACK_DATA)
                                  : OPCODE_WIDTH'(D_ACCESS_ACK);
            d_size_q   <= bus.a_size;
            d_source_q <= bus.a_source;
            d_error_q  <= req_err;
            d_rd_q     <= op_read & ~req_err;
        end
    end

    assign bus.d_valid  = (state_q == ST_RESP);
    assign bus.d_opcode = d_opcode_q;
    assign bus.d_param  = '0;
    assign bus.d_size   = d_size_q;
    assign bus.d_source = d_source_q;
    assign bus.d_sink   = '0;
    assign bus.d_error  = d_error_q;
    assign bus.d_data   = d_rd_q ? mem_rdata : '0;

    assign dbg_state_o = state_q;

    logic unused_req;
    assign unused_req = ^{bus.a_param, offset};

endmodule
